vga_timing_ctrl: RTL
====================

VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 4, meaning the number of clk cycles per pixel (legal range 1..16).
REQ-002 SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port en  input  1  when low, the divider and counters hold their values.
REQ-005 SHALL have port pixel_x  output  10  current horizontal position, 0..799.
REQ-006 SHALL have port pixel_y  output  10  current vertical position, 0..524.
REQ-007 SHALL have port video_on  output  1  high inside the 640x480 visible area.
REQ-008 SHALL have port hsync  output  1  horizontal sync, active-low.
REQ-009 SHALL have port vsync  output  1  vertical sync, active-low.
REQ-010 SHALL have port pixel_tick  output  1  one-clk pulse marking each pixel advance.
REQ-011 SHALL have port frame_start  output  1  one-clk pulse on the wrap from (799,524) to (0,0).

Function
REQ-012 SHALL implement the divider as a counter 0..DIV-1; pixel_tick is high when en is high and the divider equals DIV-1; with DIV=1, pixel_tick equals en.
REQ-013 SHALL advance pixel_x by 1 at the clk edge where pixel_tick is high, wrapping 799 -> 0.
REQ-014 SHALL advance pixel_y by 1 only on the pixel_x 799 -> 0 wrap, wrapping 524 -> 0.
REQ-015 SHALL drive pixel_x and pixel_y directly from the counter registers, with no added latency.
REQ-016 SHALL use horizontal timing of 640 visible, 16 front porch, 96 sync, 48 back porch (total 800).
REQ-017 SHALL use vertical timing of 480 visible, 10 front porch, 2 sync, 33 back porch (total 525).
REQ-018 SHALL drive video_on = (pixel_x < 640) AND (pixel_y < 480), gated low while reset is high.
REQ-019 SHALL drive hsync low iff 656 <= pixel_x <= 751, and vsync low iff 490 <= pixel_y <= 491.
REQ-020 SHALL assert frame_start in the same clk cycle as the pixel_tick that occurs at (799,524).
REQ-021 SHALL, while en is low, freeze the divider and both counters, and force pixel_tick and frame_start low; hsync, vsync and video_on continue to decode the frozen position.
REQ-022 SHALL keep the divider phase when en is deasserted and reasserted, so the next tick arrives after the remaining divider count.
REQ-023 SHALL ensure counters never leave their ranges, including immediately after reset.

Reset
REQ-024 SHALL clear the divider, pixel_x and pixel_y to 0 at the first clk edge with reset high, regardless of en.
REQ-025 SHALL hold video_on, pixel_tick and frame_start at 0, and hsync and vsync at 1, while reset is high.
REQ-026 SHALL, after reset deasserts with en high, produce the first pixel_tick DIV clk cycles later.

Configuration
REQ-027 SHALL, when macro VGA_TIMING_FRAME_CNT_EN is defined, add port frame_count  output  16, which increments on each frame_start, wraps 65535 -> 0, and resets to 0.
REQ-028 SHALL, when VGA_TIMING_FRAME_CNT_EN is undefined, have no frame_count port or logic; all other behaviour is identical.

Verification
REQ-029 SHALL cover: DIV=4, reset then en=1 -> pixel_tick every 4th clk; pixel_x reaches 1 after 4 clks and 799 after 3196 clks, then wraps to 0 with pixel_y=1.
REQ-030 SHALL cover: free-run one line -> hsync low for exactly 384 clks (96 ticks), starting at pixel_x=656; line period is 3200 clks.
REQ-031 SHALL cover: free-run two frames -> vsync low only on lines 490-491; frame_start pulses once per 1,680,000 clks; with macro defined, frame_count goes 0 -> 1 -> 2.
REQ-032 SHALL cover: video_on sampling -> high at (0,0) and (639,479); low at (640,0), (0,480) and (799,524).
REQ-033 SHALL cover: en=0 for 50 clks at pixel_x=100 mid-divider -> position and syncs hold with no ticks; after en=1, the next tick arrives after the remaining divider count.
REQ-034 SHALL cover: reset asserted at (400,300), and separately reset with frame_count=65535 -> next clk gives (0,0), hsync=vsync=1, video_on=0, frame_count=0.

Source files
------------

// File: rtl/vga_timing_ctrl.sv
// -----------------------------------------------------------------------------
// vga_timing_ctrl
//
// Purpose:
//   640x480 @ 800x525 VGA raster timing generator. A clock divider produces a
//   pixel tick every DIV clk cycles. Horizontal and vertical position counters
//   advance on that tick, and sync/blank signals are decoded from the current
//   counter values.
//
// Parameters:
//   DIV          clk cycles per pixel, legal range 1..16.
//
// Ports:
//   clk          system clock; all logic runs on its rising edge.
//   reset        synchronous, active-high reset.
//   en           when low, the divider and both counters hold their values.
//   pixel_x      current horizontal position, 0..799.
//   pixel_y      current vertical position, 0..524.
//   video_on     high inside the 640x480 visible area.
//   hsync        horizontal sync, active-low (pixel_x 656..751).
//   vsync        vertical sync, active-low (pixel_y 490..491).
//   pixel_tick   one-clk pulse marking each pixel advance.
//   frame_start  one-clk pulse on the wrap from (799,524) to (0,0).
//   frame_count  (only when VGA_TIMING_FRAME_CNT_EN is defined) 16-bit count
//                of frame_start pulses; wraps 65535 -> 0 and resets to 0.
//
// Build option:
//   VGA_TIMING_FRAME_CNT_EN  adds the frame_count port and its counter.
// -----------------------------------------------------------------------------
module vga_timing_ctrl #(
    parameter int DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        video_on,
    output logic        hsync,
    output logic        vsync,
    output logic        pixel_tick,
    output logic        frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0] frame_count
`endif
);

    // Horizontal timing: 640 visible, 16 front porch, 96 sync, 48 back porch.
    localparam logic [9:0] H_VISIBLE    = 10'd640;
    localparam logic [9:0] H_SYNC_START = 10'd656;
    localparam logic [9:0] H_SYNC_END   = 10'd752;  // first pixel after sync
    localparam logic [9:0] H_LAST       = 10'd799;

    // Vertical timing: 480 visible, 10 front porch, 2 sync, 33 back porch.
    localparam logic [9:0] V_VISIBLE    = 10'd480;
    localparam logic [9:0] V_SYNC_START = 10'd490;
    localparam logic [9:0] V_SYNC_END   = 10'd492;  // first line after sync
    localparam logic [9:0] V_LAST       = 10'd524;

    // DIV=1 still needs a 1-bit divider register; it simply never leaves 0.
    localparam int              DW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0]   DIV_LAST = DW'(DIV - 1);

    logic [DW-1:0] div_q, div_d;
    logic [9:0]    x_q, x_d;
    logic [9:0]    y_q, y_d;

    logic tick;
    logic x_last;
    logic y_last;

    // Tick is decoded from the divider phase, so it is valid in the same
    // cycle the counters see it and advance on the following edge.
    assign tick   = en && (div_q == DIV_LAST);
    // ">=" keeps the counters inside their ranges even if a register were
    // ever to hold an out-of-range value.
    assign x_last = (x_q >= H_LAST);
    assign y_last = (y_q >= V_LAST);

    always_comb begin
        div_d = div_q;
        x_d   = x_q;
        y_d   = y_q;
        if (en) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        end
        if (tick) begin
            x_d = x_last ? 10'd0 : x_q + 10'd1;
            if (x_last) begin
                y_d = y_last ? 10'd0 : y_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
            x_q   <= 10'd0;
            y_q   <= 10'd0;
        end else begin
            div_q <= div_d;
            x_q   <= x_d;
            y_q   <= y_d;
        end
    end

    assign pixel_x = x_q;
    assign pixel_y = y_q;

    // All strobes and decodes are forced to their idle levels during reset,
    // since the registers only clear on the first reset edge.
    assign pixel_tick  = tick && !reset;
    assign frame_start = pixel_tick && x_last && y_last;
    assign video_on    = !reset && (x_q < H_VISIBLE) && (y_q < V_VISIBLE);
    assign hsync       = reset || !((x_q >= H_SYNC_START) && (x_q < H_SYNC_END));
    assign vsync       = reset || !((y_q >= V_SYNC_START) && (y_q < V_SYNC_END));

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Natural 16-bit overflow gives the 65535 -> 0 wrap.
    assign frame_cnt_d = frame_start ? frame_cnt_q + 16'd1 : frame_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= 16'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_count = frame_cnt_q;
`endif

endmodule
